// File: rtl/pcs_pkg.sv
// Shared PCS definitions: sync header codes and the block-lock state encoding.
// Also used by the descrambler and the XGMII decoder.
package pcs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [1:0] {
    RESET_CNT = 2'd0,
    TEST_SH   = 2'd1,
    SLIP_WAIT = 2'd2
  } bl_state_e;

endpackage

// File: rtl/rx_block_lock.sv
// 64b/66b receive block synchronizer. Checks the sync header of each block,
// asks the gearbox to slip one bit until headers line up, reports block lock
// and keeps a saturating count of invalid headers seen while locked.
module rx_block_lock
  import pcs_pkg::*;
#(
  parameter int HDR_WIDTH     = 2,
  parameter int SH_CNT_MAX    = 64,
  parameter int SH_INVLD_MAX  = 16,
  parameter int SLIP_WAIT     = 32,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [HDR_WIDTH-1:0]     i_rx_hdr,
  input  logic                     i_rx_hdr_valid,
  output logic                     o_slip,
  output logic                     o_block_lock,
  output logic [ERR_CNT_WIDTH-1:0] o_invld_hdr_cnt
);

  localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [SH_W-1:0]          SH_LAST   = SH_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]         INV_LAST  = INV_W'(SH_INVLD_MAX);
  localparam logic [WAIT_W-1:0]        WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_SAT   = '1;

  // The parameter SLIP_WAIT shadows the enum literal of the same name, so
  // the state literal is always referenced through the package scope.
  bl_state_e state, state_nxt;

  logic [SH_W-1:0]          sh_cnt, sh_cnt_nxt, sh_base, sh_inc;
  logic [INV_W-1:0]         invld_cnt, invld_nxt, invld_base, invld_inc;
  logic [WAIT_W-1:0]        wait_cnt, wait_nxt;
  logic [ERR_CNT_WIDTH-1:0] err_nxt;
  logic                     lock_nxt, slip_nxt, hdr_ok;

  assign hdr_ok = (i_rx_hdr == HDR_WIDTH'(SYNC_DATA)) ||
                  (i_rx_hdr == HDR_WIDTH'(SYNC_CTRL));

  // RESET_CNT evaluates a header as if the window counters were already
  // zero, so a header arriving in that cycle is never dropped.
  assign sh_base    = (state == RESET_CNT) ? '0 : sh_cnt;
  assign invld_base = (state == RESET_CNT) ? '0 : invld_cnt;
  assign sh_inc     = sh_base + SH_W'(1);
  assign invld_inc  = invld_base + INV_W'(1);

  // Next-state, counter and output decode.
  always_comb begin
    state_nxt  = state;
    sh_cnt_nxt = sh_cnt;
    invld_nxt  = invld_cnt;
    wait_nxt   = wait_cnt;
    lock_nxt   = o_block_lock;
    slip_nxt   = 1'b0;
    err_nxt    = o_invld_hdr_cnt;
    case (state)
      RESET_CNT, TEST_SH: begin
        state_nxt  = TEST_SH;
        sh_cnt_nxt = sh_base;
        invld_nxt  = invld_base;
        wait_nxt   = '0;
        if (i_rx_hdr_valid) begin
          sh_cnt_nxt = sh_inc;
          if (!o_block_lock) begin
            // Hunting: any bad header means wrong alignment, slip at once.
            if (!hdr_ok) begin
              slip_nxt  = 1'b1;
              state_nxt = pcs_pkg::SLIP_WAIT;
            end else if (sh_inc == SH_LAST) begin
              lock_nxt  = 1'b1;
              state_nxt = RESET_CNT;
            end
          end else begin
            if (!hdr_ok) begin
              invld_nxt = invld_inc;
              if (o_invld_hdr_cnt != ERR_SAT)
                err_nxt = o_invld_hdr_cnt + ERR_CNT_WIDTH'(1);
            end
            // Too many bad headers wins over a window that ends on the same header.
            if (!hdr_ok && (invld_inc == INV_LAST)) begin
              lock_nxt  = 1'b0;
              slip_nxt  = 1'b1;
              state_nxt = pcs_pkg::SLIP_WAIT;
            end else if (sh_inc == SH_LAST) begin
              state_nxt = RESET_CNT;
            end
          end
        end
      end
      pcs_pkg::SLIP_WAIT: begin
        // Give the gearbox time to realign; headers are ignored meanwhile.
        if (wait_cnt == WAIT_LAST) begin
          wait_nxt  = '0;
          state_nxt = RESET_CNT;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      default: state_nxt = RESET_CNT;
    endcase
  end

  // State, counters and registered outputs; reset overrides everything.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state           <= RESET_CNT;
      sh_cnt          <= '0;
      invld_cnt       <= '0;
      wait_cnt        <= '0;
      o_block_lock    <= 1'b0;
      o_slip          <= 1'b0;
      o_invld_hdr_cnt <= '0;
    end else begin
      state           <= state_nxt;
      sh_cnt          <= sh_cnt_nxt;
      invld_cnt       <= invld_nxt;
      wait_cnt        <= wait_nxt;
      o_block_lock    <= lock_nxt;
      o_slip          <= slip_nxt;
      o_invld_hdr_cnt <= err_nxt;
    end
  end

endmodule

// File: tb/tb_rx_block_lock.sv
// Bench for rx_block_lock: a behavioural reference model feeds a scoreboard
// every cycle, and scenario checks compare against hand-derived constants.
// The error counter is built 8 bits wide so saturation is reachable quickly.
module tb_rx_block_lock;

  localparam int EW     = 8;
  localparam int ERRMAX = (1 << EW) - 1;

  logic          clk;
  logic          rst;
  logic [1:0]    rx_hdr;
  logic          hdr_valid;
  logic          slip;
  logic          block_lock;
  logic [EW-1:0] invld_cnt;

  rx_block_lock #(
    .HDR_WIDTH(2), .SH_CNT_MAX(64), .SH_INVLD_MAX(16),
    .SLIP_WAIT(32), .ERR_CNT_WIDTH(EW)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_hdr(rx_hdr), .i_rx_hdr_valid(hdr_valid),
    .o_slip(slip), .o_block_lock(block_lock), .o_invld_hdr_cnt(invld_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          lock;
    logic          slp;
    logic [EW-1:0] err;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   slips_seen = 0;
  bit   gap_mode = 0;

  // reference model state: 0 reset_cnt, 1 test_sh, 2 slip_wait
  int m_state, m_sh, m_inv, m_wait, m_lock, m_slip, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model(input logic r, input logic v, input logic [1:0] h);
    int  sh, inv;
    bit  good;
    m_slip = 0;
    if (r) begin
      m_state = 0; m_sh = 0; m_inv = 0; m_wait = 0; m_lock = 0; m_err = 0;
    end else if (m_state == 2) begin
      if (m_wait == 31) begin m_state = 0; m_wait = 0; end
      else m_wait++;
    end else begin
      sh   = (m_state == 0) ? 0 : m_sh;
      inv  = (m_state == 0) ? 0 : m_inv;
      good = (h == 2'b01) || (h == 2'b10);
      m_state = 1;
      if (v) begin
        sh++;
        if (m_lock == 0) begin
          if (!good) begin m_slip = 1; m_state = 2; m_wait = 0; end
          else if (sh == 64) begin m_lock = 1; m_state = 0; end
        end else begin
          if (!good) begin
            inv++;
            if (m_err < ERRMAX) m_err++;
          end
          if (inv == 16) begin m_lock = 0; m_slip = 1; m_state = 2; m_wait = 0; end
          else if (sh == 64) m_state = 0;
        end
      end
      m_sh = sh; m_inv = inv;
    end
  endtask

  // One clock: drive inputs, push model prediction, compare after the edge.
  task automatic step(input logic r, input logic v, input logic [1:0] h);
    exp_t e;
    rst = r; hdr_valid = v; rx_hdr = h;
    model(r, v, h);
    sb.push_back('{lock: m_lock[0], slp: m_slip[0], err: m_err[EW-1:0]});
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("sb_lock", {31'd0, block_lock}, {31'd0, e.lock});
    chk("sb_slip", {31'd0, slip}, {31'd0, e.slp});
    chk("sb_err", {24'd0, invld_cnt}, {24'd0, e.err});
    slips_seen += int'(slip);
  endtask

  // One header; in gap mode an idle cycle precedes it (32-bit path cadence).
  task automatic send(input logic [1:0] h);
    if (gap_mode) step(1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b1, h);
  endtask

  task automatic send_good(input int n);
    for (int i = 0; i < n; i++) send((i % 2 == 0) ? 2'b01 : 2'b10);
  endtask

  // Full window with 15 invalid headers at indices 3,7,...,59.
  task automatic window15();
    for (int i = 0; i < 64; i++)
      send((i % 4 == 3 && i < 60) ? ((i % 8 == 3) ? 2'b11 : 2'b00) : 2'b10);
  endtask

  initial begin
    rst = 1'b1; hdr_valid = 1'b0; rx_hdr = 2'b00;
    step(1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b1, 2'b11);
    chk("rst_lock", {31'd0, block_lock}, 32'd0);
    chk("rst_slip", {31'd0, slip}, 32'd0);
    chk("rst_err", {24'd0, invld_cnt}, 32'd0);

    // 1: 64 alternating valid headers on the every-other-word cadence
    gap_mode = 1; slips_seen = 0;
    send_good(63);
    chk("t1_lock63", {31'd0, block_lock}, 32'd0);
    send_good(1);
    chk("t1_lock64", {31'd0, block_lock}, 32'd1);
    chk("t1_noslip", slips_seen, 32'd0);
    chk("t1_err", {24'd0, invld_cnt}, 32'd0);

    // 2: unlocked slip on the 10th header, wait ignores headers, relock
    gap_mode = 0;
    step(1'b1, 1'b0, 2'b00);
    slips_seen = 0;
    send_good(9);
    send(2'b00);
    chk("t2_slip", {31'd0, slip}, 32'd1);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, (i % 3 == 0) ? 2'b11 : 2'b01);
    send_good(63);
    chk("t2_lock63", {31'd0, block_lock}, 32'd0);
    send_good(1);
    chk("t2_lock", {31'd0, block_lock}, 32'd1);
    chk("t2_oneslip", slips_seen, 32'd1);

    // 3: two windows of 15 invalid hold lock; 16th invalid at header 20 drops it
    window15();
    chk("t3_lock_w1", {31'd0, block_lock}, 32'd1);
    chk("t3_err15", {24'd0, invld_cnt}, 32'd15);
    window15();
    chk("t3_lock_w2", {31'd0, block_lock}, 32'd1);
    chk("t3_err30", {24'd0, invld_cnt}, 32'd30);
    for (int i = 0; i < 19; i++) send((i >= 4) ? 2'b11 : 2'b01);
    chk("t3_lock19", {31'd0, block_lock}, 32'd1);
    send(2'b00);
    chk("t3_unlock", {31'd0, block_lock}, 32'd0);
    chk("t3_slip", {31'd0, slip}, 32'd1);
    chk("t3_err46", {24'd0, invld_cnt}, 32'd46);
    step(1'b0, 1'b0, 2'b00);
    chk("t3_slip1cyc", {31'd0, slip}, 32'd0);

    // 4: 16th invalid lands on the 64th header of a window
    for (int i = 0; i < 31; i++) step(1'b0, 1'b1, 2'b00);
    send_good(64);
    chk("t4_lock", {31'd0, block_lock}, 32'd1);
    for (int i = 0; i < 63; i++) send((i % 4 == 3 && i < 60) ? 2'b11 : 2'b01);
    chk("t4_lock63", {31'd0, block_lock}, 32'd1);
    send(2'b11);
    chk("t4_unlock", {31'd0, block_lock}, 32'd0);
    chk("t4_slip", {31'd0, slip}, 32'd1);
    chk("t4_err", {24'd0, invld_cnt}, 32'd62);

    // 5: reset mid-window and during slip wait
    step(1'b1, 1'b0, 2'b00);
    send_good(40);
    step(1'b1, 1'b1, 2'b01);
    chk("t5_lock", {31'd0, block_lock}, 32'd0);
    chk("t5_slip", {31'd0, slip}, 32'd0);
    chk("t5_err", {24'd0, invld_cnt}, 32'd0);
    send_good(24);
    chk("t5_nolock", {31'd0, block_lock}, 32'd0);
    send(2'b11);
    chk("t5_slip2", {31'd0, slip}, 32'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 2'b01);
    step(1'b1, 1'b1, 2'b01);
    chk("t5_wrst_lock", {31'd0, block_lock}, 32'd0);
    chk("t5_wrst_slip", {31'd0, slip}, 32'd0);
    send_good(63);
    chk("t5_lock63", {31'd0, block_lock}, 32'd0);
    send_good(1);
    chk("t5_relock", {31'd0, block_lock}, 32'd1);

    // 6: saturation of the invalid counter, lock held by 15-per-window
    for (int w = 0; w < 17; w++) window15();
    chk("t6_err255", {24'd0, invld_cnt}, ERRMAX);
    window15();
    chk("t6_sat", {24'd0, invld_cnt}, ERRMAX);
    chk("t6_lock", {31'd0, block_lock}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
